// File: rtl/alu_mdu_seq_if.sv
// rtl/alu_mdu_seq_if.sv - request/response bundle between EX control and the ALU/MDU
interface alu_mdu_seq_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, alu_op, a, b, shamt,
        input  in_ready, result_valid, result, zero, overflow, div_by_zero, hi, lo
    );

    modport slave (
        input  in_valid, alu_op, a, b, shamt,
        output in_ready, result_valid, result, zero, overflow, div_by_zero, hi, lo
    );
endinterface

// File: rtl/alu_mdu_seq.sv
// rtl/alu_mdu_seq.sv - single-cycle ALU with iterative multiply/divide and HI/LO registers
module alu_mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    alu_mdu_seq_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    state_t state_q, state_d;

    logic [SHW-1:0]   cnt;
    logic             is_div, neg_q, neg_r, dbz_q;
    logic [WIDTH-1:0] a_raw, opb, phi, plo;
    logic [WIDTH-1:0] hi_q, lo_q, result_q;
    logic             result_valid_q, zero_q, overflow_q, div_by_zero_q;

    logic             accept, iter_op, sgn_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, sum, diff, alu_res;
    logic             alu_ovf;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub, quo_fix, rem_fix, new_hi, new_lo;
    logic [2*WIDTH-1:0] prod_fix;

    assign accept  = bus.in_valid && bus.in_ready;
    assign iter_op = (bus.alu_op >= 4'd10) && (bus.alu_op <= 4'd13);
    assign sgn_op  = (bus.alu_op == 4'd10) || (bus.alu_op == 4'd12);
    assign a_neg   = sgn_op && bus.a[WIDTH-1];
    assign b_neg   = sgn_op && bus.b[WIDTH-1];
    assign a_mag   = a_neg ? -bus.a : bus.a;
    assign b_mag   = b_neg ? -bus.b : bus.b;

    assign bus.in_ready     = (state_q == IDLE);
    assign bus.result_valid = result_valid_q;
    assign bus.result       = result_q;
    assign bus.zero         = zero_q;
    assign bus.overflow     = overflow_q;
    assign bus.div_by_zero  = div_by_zero_q;
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;

    always_comb begin
        sum     = bus.a + bus.b;
        diff    = bus.a - bus.b;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.alu_op)
            4'd0:  alu_res = bus.a & bus.b;
            4'd1:  alu_res = bus.a | bus.b;
            4'd2:  alu_res = ~(bus.a | bus.b);
            4'd3: begin
                alu_res = sum;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd4: begin
                alu_res = diff;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd5:  alu_res = bus.a << bus.shamt;
            4'd6:  alu_res = bus.a >> bus.shamt;
            4'd7:  alu_res = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            4'd8:  alu_res = $unsigned($signed(bus.a) >>> bus.shamt);
            4'd9:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            4'd14: alu_res = hi_q;
            4'd15: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // phi/plo double as product accumulator (mult) or remainder/quotient pair (div)
    always_comb begin
        mul_sum   = {1'b0, phi} + (plo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        div_shift = {phi, plo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opb};
        div_sub   = div_shift[WIDTH-1:0] - opb;
        prod_fix  = neg_q ? -{phi, plo} : {phi, plo};
        quo_fix   = neg_q ? -plo : plo;
        rem_fix   = neg_r ? -phi : phi;
        if (is_div) begin
            new_hi = dbz_q ? a_raw : rem_fix;
            new_lo = dbz_q ? {WIDTH{1'b1}} : quo_fix;
        end else begin
            new_hi = prod_fix[2*WIDTH-1:WIDTH];
            new_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && iter_op) state_d = ITER;
            ITER:    if (cnt == '0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt            <= '0;
            is_div         <= 1'b0;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            dbz_q          <= 1'b0;
            a_raw          <= '0;
            opb            <= '0;
            phi            <= '0;
            plo            <= '0;
            hi_q           <= '0;
            lo_q           <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            zero_q         <= 1'b0;
            overflow_q     <= 1'b0;
            div_by_zero_q  <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            if (accept && !iter_op) begin
                result_q       <= alu_res;
                result_valid_q <= 1'b1;
                zero_q         <= (alu_res == '0);
                overflow_q     <= alu_ovf;
                div_by_zero_q  <= 1'b0;
            end
            if (accept && iter_op) begin
                cnt    <= SHW'(WIDTH-1);
                is_div <= bus.alu_op[3] && bus.alu_op[2];
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                dbz_q  <= (bus.b == '0);
                a_raw  <= bus.a;
                opb    <= b_mag;
                phi    <= '0;
                plo    <= a_mag;
            end
            case (state_q)
                ITER: begin
                    cnt <= cnt - 1'b1;
                    if (is_div) begin
                        phi <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                        plo <= {plo[WIDTH-2:0], div_ge};
                    end else begin
                        phi <= mul_sum[WIDTH:1];
                        plo <= {mul_sum[0], plo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    hi_q           <= new_hi;
                    lo_q           <= new_lo;
                    result_q       <= new_lo;
                    result_valid_q <= 1'b1;
                    zero_q         <= (new_lo == '0);
                    overflow_q     <= 1'b0;
                    div_by_zero_q  <= is_div && dbz_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb/tb_alu_mdu_seq.sv - directed self-checking bench for alu_mdu_seq (WIDTH 32 and 8)
module tb_alu_mdu_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_mdu_seq_if #(.WIDTH(32)) bus ();
    alu_mdu_seq_if #(.WIDTH(8))  bus8 ();

    alu_mdu_seq #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    alu_mdu_seq #(.WIDTH(8))  dut8 (.clk(clk), .reset(reset), .bus(bus8));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input logic [4:0] sh);
        @(negedge clk);
        bus.in_valid = v;
        bus.alu_op   = op;
        bus.a        = av;
        bus.b        = bv;
        bus.shamt    = sh;
    endtask

    task automatic run_iter(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                            input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                            input logic exp_dbz, input string tag);
        int n;
        int low;
        bit got;
        n = 0;
        low = 0;
        got = 1'b0;
        drive(1'b1, op, av, bv, 5'd0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.result_valid) got = 1'b1;
            else if (!bus.in_ready) low++;
        end
        check({tag, " latency"}, n, 34);
        check({tag, " ready_low"}, low, 33);
        check({tag, " ready_back"}, bus.in_ready, 1'b1);
        check({tag, " result"}, bus.result, exp_lo);
        check({tag, " lo"}, bus.lo, exp_lo);
        check({tag, " hi"}, bus.hi, exp_hi);
        check({tag, " dbz"}, bus.div_by_zero, exp_dbz);
        check({tag, " ovf"}, bus.overflow, 1'b0);
    endtask

    initial begin
        int n;
        int pulses;
        bit got;
        bus.in_valid = 1'b0; bus.alu_op = 4'd0; bus.a = '0; bus.b = '0; bus.shamt = '0;
        bus8.in_valid = 1'b0; bus8.alu_op = 4'd0; bus8.a = '0; bus8.b = '0; bus8.shamt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("rst in_ready", bus.in_ready, 1'b1);
        check("rst result_valid", bus.result_valid, 1'b0);
        check("rst result", bus.result, 32'h0);
        check("rst hi", bus.hi, 32'h0);
        check("rst lo", bus.lo, 32'h0);
        check("rst zero", bus.zero, 1'b0);

        drive(1'b1, 4'd3, 32'd7, 32'd5, 5'd0);
        drive(1'b1, 4'd4, 32'd5, 32'd5, 5'd0);
        check("add rv", bus.result_valid, 1'b1);
        check("add result", bus.result, 32'd12);
        check("add zero", bus.zero, 1'b0);
        check("add in_ready", bus.in_ready, 1'b1);
        drive(1'b1, 4'd3, 32'h7FFF_FFFF, 32'd1, 5'd0);
        check("sub rv", bus.result_valid, 1'b1);
        check("sub result", bus.result, 32'd0);
        check("sub zero", bus.zero, 1'b1);
        drive(1'b1, 4'd8, 32'h8000_0000, 32'd0, 5'd4);
        check("addovf result", bus.result, 32'h8000_0000);
        check("addovf ovf", bus.overflow, 1'b1);
        drive(1'b1, 4'd9, 32'hFFFF_FFFF, 32'd1, 5'd0);
        check("sra result", bus.result, 32'hF800_0000);
        check("sra ovf", bus.overflow, 1'b0);
        drive(1'b1, 4'd7, 32'd0, 32'h0000_1234, 5'd0);
        check("slt result", bus.result, 32'd1);
        drive(1'b1, 4'd6, 32'h8000_0000, 32'd0, 5'd4);
        check("lui result", bus.result, 32'h1234_0000);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        check("srl result", bus.result, 32'h0800_0000);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        check("idle rv", bus.result_valid, 1'b0);
        check("hold result", bus.result, 32'h0800_0000);

        run_iter(4'd10, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, "mult");
        drive(1'b1, 4'd14, 32'd0, 32'd0, 5'd0);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        check("mfhi result", bus.result, 32'hFFFF_FFFF);

        run_iter(4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "div");
        run_iter(4'd13, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0, "divu");
        run_iter(4'd13, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b1, "divu0");
        run_iter(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, "divmin");
        drive(1'b1, 4'd15, 32'd0, 32'd0, 5'd0);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        check("mflo result", bus.result, 32'h8000_0000);
        check("mflo dbz", bus.div_by_zero, 1'b0);

        drive(1'b1, 4'd11, 32'd3, 32'd5, 5'd0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("abort hi", bus.hi, 32'h0);
        check("abort lo", bus.lo, 32'h0);
        check("abort result", bus.result, 32'h0);
        check("abort in_ready", bus.in_ready, 1'b1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.result_valid) pulses++;
        end
        check("abort pulses", pulses, 0);

        @(negedge clk);
        bus8.in_valid = 1'b1; bus8.alu_op = 4'd11; bus8.a = 8'hFF; bus8.b = 8'hFF;
        @(posedge clk);
        #1 bus8.in_valid = 1'b0;
        n = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            if (bus8.result_valid) got = 1'b1;
        end
        check("w8 latency", n, 10);
        check("w8 hi", bus8.hi, 8'hFE);
        check("w8 lo", bus8.lo, 8'h01);
        check("w8 result", bus8.result, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
